// File: rtl/fifo_reg.sv
// fifo_reg: synchronous register-array FIFO with registered read data.
// DEPTH entries of WIDTH bits; DEPTH need not be a power of two.
// Optional macro FIFO_REG_ERR_EN adds sticky overflow_o / underflow_o flags.
module fifo_reg #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef FIFO_REG_ERR_EN
    ,
    output logic                     overflow_o,
    output logic                     underflow_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             wr_acc, rd_acc;

    // Status flags, request acceptance and next-state for pointers, count and read data
    always_comb begin
        full_o   = (count_q == CNT_FULL);
        empty_o  = (count_q == '0);
        wr_acc   = wr_en_i && !full_o;
        rd_acc   = rd_en_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            // Head word is taken from storage before this edge's write lands
            dout_d   = mem_q[rd_ptr_q];
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage array write port; contents are never cleared
    always_ff @(posedge clk_i) begin
        if (!reset_i && wr_acc) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = dout_q;
    assign count_o = count_q;

`ifdef FIFO_REG_ERR_EN
    logic overflow_q, underflow_q;

    // Sticky error flags for rejected requests, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en_i && !wr_acc) begin
                overflow_q <= 1'b1;
            end
            if (rd_en_i && !rd_acc) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

endmodule
